// File: rtl/mux_n_pipe.sv
// mux_n_pipe: NUM_IN-way channel select into a 2-entry (main + skid) output buffer.
// Define MUX_N_PIPE_SEL_CHECK_EN to get a sticky err flag on out-of-range selects.
module mux_n_pipe #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    err
);
    if (2**SEL_W < NUM_IN) begin : g_bad_sel_w
        $error("mux_n_pipe: SEL_W too small for NUM_IN");
    end

    // Unused select codes map to zero so out-of-range transfers carry all-zero data.
    logic [WIDTH-1:0] chan [2**SEL_W];
    for (genvar k = 0; k < 2**SEL_W; k++) begin : g_chan
        if (k < NUM_IN) begin : g_used
            assign chan[k] = in_data[k*WIDTH +: WIDTH];
        end else begin : g_unused
            assign chan[k] = '0;
        end
    end

    logic [WIDTH-1:0] skid_data;
    logic [SEL_W-1:0] skid_sel;
    logic             skid_valid;
    logic             accept;

    assign accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data   <= '0;
            out_sel    <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_sel   <= '0;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (!out_valid || out_ready) begin
            // Main is free this cycle: refill from skid first to keep FIFO order.
            out_valid  <= skid_valid || accept;
            out_data   <= skid_valid ? skid_data : accept ? chan[in_sel] : out_data;
            out_sel    <= skid_valid ? skid_sel : accept ? in_sel : out_sel;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
        end else if (accept) begin
            skid_data  <= chan[in_sel];
            skid_sel   <= in_sel;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
        end
    end

`ifdef MUX_N_PIPE_SEL_CHECK_EN
    logic [2**SEL_W-1:0] in_range;
    for (genvar j = 0; j < 2**SEL_W; j++) begin : g_range
        assign in_range[j] = (j < NUM_IN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) err <= 1'b0;
        else if (accept && !in_range[in_sel]) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif
endmodule
